// File: rtl/cbus_sram_responder.sv
// cbus slave that serves single and burst reads/writes from a synchronous 32-bit SRAM.
// Reads are pipelined one beat ahead of the response so bursts stream back-to-back.
package cbus_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } cbus_size_t;

  // Encoded as beat count minus one.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_sram_responder
  import cbus_pkg::*;
#(
  parameter int unsigned SRAM_AW = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  cbus_req_t          creq,
  output cbus_resp_t         cresp,
  output logic               sram_en,
  output logic [3:0]         sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  localparam int unsigned WORD_AW = 30;
  localparam int unsigned LEN_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WORD_AW-1:0] r_addr;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_idx;
  logic               r_is_write;
  logic [3:0]         r_strobe;

  logic [WORD_AW-1:0] w_beat_addr;
  logic [WORD_AW-1:0] w_next_addr;
  logic               w_is_last;
  logic               w_unused;

  assign w_beat_addr = r_addr + WORD_AW'(r_idx);
  assign w_next_addr = w_beat_addr + WORD_AW'(1);
  assign w_is_last   = (r_idx == r_len);
  // Byte offset and size never affect word addressing.
  assign w_unused    = ^{creq.size, creq.addr[1:0], w_beat_addr, w_next_addr};

  // State and burst bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_is_write <= 1'b0;
      r_strobe   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (creq.valid) begin
            r_addr     <= creq.addr[31:2];
            r_len      <= creq.len;
            r_is_write <= creq.is_write;
            r_strobe   <= creq.strobe;
            r_idx      <= '0;
            r_state    <= creq.is_write ? WRITE : READ;
          end
        end
        READ, WRITE: begin
          if (!creq.valid || w_is_last) begin
            r_idx   <= '0;
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx + LEN_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus handshake and SRAM port; read data is forwarded straight from the SRAM.
  always_comb begin
    cresp      = '0;
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (r_state)
      IDLE: begin
        if (resetn && creq.valid && !creq.is_write) begin
          sram_en   = 1'b1;
          sram_addr = SRAM_AW'(creq.addr[31:2]);
        end
      end
      READ: begin
        if (creq.valid) begin
          cresp.ready = 1'b1;
          cresp.last  = w_is_last;
          cresp.data  = sram_rdata;
          if (!w_is_last) begin
            sram_en   = 1'b1;
            sram_addr = SRAM_AW'(w_next_addr);
          end
        end
      end
      WRITE: begin
        if (creq.valid) begin
          cresp.ready = 1'b1;
          cresp.last  = w_is_last;
          sram_en     = 1'b1;
          sram_we     = r_is_write ? r_strobe : 4'b0000;
          sram_addr   = SRAM_AW'(w_beat_addr);
          sram_wdata  = creq.data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Directed bench for cbus_sram_responder with a one-cycle-latency SRAM model.
module tb_cbus_sram_responder;
  import cbus_pkg::*;

  localparam int unsigned AW = 16;

  localparam logic [31:0] A_WORDS [4] = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
  localparam logic [31:0] D_WORDS [4] = '{32'hD000_0D00, 32'hD111_1D11, 32'hD222_2D22, 32'hD333_3D33};
  localparam logic [31:0] E_WORDS [4] = '{32'hE0E0_0E0E, 32'hE1E1_1E1E, 32'hE2E2_2E2E, 32'hE3E3_3E3E};
  localparam logic [31:0] F_WORDS [4] = '{32'hF000_000F, 32'hF111_111F, 32'hF222_222F, 32'hF333_333F};

  logic          clk = 1'b0;
  logic          resetn;
  cbus_req_t     creq;
  cbus_resp_t    cresp;
  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;

  logic [31:0]   mem [1024];
  logic          loaded = 1'b0;
  logic [31:0]   w_mask;

  int n_cmp = 0;
  int n_err = 0;

  cbus_sram_responder #(.SRAM_AW(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .creq       (creq),
    .cresp      (cresp),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  assign w_mask = {{8{sram_we[3]}}, {8{sram_we[2]}}, {8{sram_we[1]}}, {8{sram_we[0]}}};

  // SRAM model: first edge preloads the words the directed tests rely on.
  always @(posedge clk) begin
    if (!loaded) begin
      mem[10'h100] <= A_WORDS[0];
      mem[10'h101] <= A_WORDS[1];
      mem[10'h102] <= A_WORDS[2];
      mem[10'h103] <= A_WORDS[3];
      mem[10'h011] <= 32'h1122_3344;
      mem[10'h030] <= 32'h5555_0000;
      mem[10'h031] <= 32'h5555_0001;
      mem[10'h032] <= 32'h5555_0002;
      mem[10'h033] <= 32'h5555_0003;
      loaded       <= 1'b1;
    end else if (sram_en) begin
      mem[sram_addr[9:0]] <= (mem[sram_addr[9:0]] & ~w_mask) | (sram_wdata & w_mask);
      sram_rdata          <= mem[sram_addr[9:0]];
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    creq   = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (cresp !== '0) begin n_err++; $display("FAIL rst_cresp: got %h want 0", cresp); end
    n_cmp++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b want 0", sram_en); end
    n_cmp++; if (sram_we !== 4'h0) begin n_err++; $display("FAIL rst_we: got %h want 0", sram_we); end
    n_cmp++; if (sram_addr !== 16'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", sram_addr); end
    n_cmp++; if (sram_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", sram_wdata); end
    creq.valid = 1'b1;
    creq.addr  = 32'h400;
    creq.len   = MLEN4;
    #1;
    n_cmp++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL rst_valid_en: got %b want 0", sram_en); end
    n_cmp++; if (sram_addr !== 16'h0) begin n_err++; $display("FAIL rst_valid_addr: got %h want 0", sram_addr); end
    @(negedge clk);
    creq   = '0;
    resetn = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (cresp !== '0) begin n_err++; $display("FAIL post_rst_cresp: got %h want 0", cresp); end
    n_cmp++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL post_rst_en: got %b want 0", sram_en); end
    @(negedge clk);
  endtask

  task automatic test_read_burst();
    creq       = '0;
    creq.valid = 1'b1;
    creq.size  = MSIZE4;
    creq.addr  = 32'h400;
    creq.len   = MLEN4;
    #1;
    n_cmp++; if (sram_en !== 1'b1) begin n_err++; $display("FAIL rd_issue_en: got %b want 1", sram_en); end
    n_cmp++; if (sram_addr !== 16'h0100) begin n_err++; $display("FAIL rd_issue_addr: got %h want 0100", sram_addr); end
    n_cmp++; if (cresp.ready !== 1'b0) begin n_err++; $display("FAIL rd_issue_ready: got %b want 0", cresp.ready); end
    @(negedge clk);
    // Non-data fields are scrambled mid-burst; the latched copy must govern.
    creq.addr     = 32'h0000_FFF0;
    creq.len      = MLEN1;
    creq.is_write = 1'b1;
    creq.strobe   = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (cresp.ready !== 1'b1) begin n_err++; $display("FAIL rd_ready[%0d]: got %b want 1", i, cresp.ready); end
      n_cmp++; if (cresp.data !== A_WORDS[i]) begin n_err++; $display("FAIL rd_data[%0d]: got %h want %h", i, cresp.data, A_WORDS[i]); end
      n_cmp++; if (cresp.last !== (i == 3)) begin n_err++; $display("FAIL rd_last[%0d]: got %b want %b", i, cresp.last, (i == 3)); end
      n_cmp++; if (sram_we !== 4'h0) begin n_err++; $display("FAIL rd_we[%0d]: got %h want 0", i, sram_we); end
      if (i < 3) begin
        n_cmp++; if (sram_addr !== AW'(32'h101 + i)) begin n_err++; $display("FAIL rd_next_addr[%0d]: got %h want %h", i, sram_addr, AW'(32'h101 + i)); end
      end else begin
        n_cmp++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL rd_last_en: got %b want 0", sram_en); end
      end
      @(negedge clk);
    end
    creq = '0;
    #1;
    n_cmp++; if (cresp.ready !== 1'b0) begin n_err++; $display("FAIL rd_after_ready: got %b want 0", cresp.ready); end
    @(negedge clk);
  endtask

  task automatic test_write_burst();
    creq          = '0;
    creq.valid    = 1'b1;
    creq.is_write = 1'b1;
    creq.size     = MSIZE4;
    creq.addr     = 32'h20;
    creq.len      = MLEN4;
    creq.strobe   = 4'hF;
    creq.data     = D_WORDS[0];
    #1;
    n_cmp++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL wr_issue_en: got %b want 0", sram_en); end
    n_cmp++; if (cresp.ready !== 1'b0) begin n_err++; $display("FAIL wr_issue_ready: got %b want 0", cresp.ready); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      creq.data = D_WORDS[i];
      #1;
      n_cmp++; if (cresp.ready !== 1'b1) begin n_err++; $display("FAIL wr_ready[%0d]: got %b want 1", i, cresp.ready); end
      n_cmp++; if (cresp.last !== (i == 3)) begin n_err++; $display("FAIL wr_last[%0d]: got %b want %b", i, cresp.last, (i == 3)); end
      n_cmp++; if (sram_we !== 4'hF) begin n_err++; $display("FAIL wr_we[%0d]: got %h want f", i, sram_we); end
      n_cmp++; if (sram_addr !== AW'(32'h8 + i)) begin n_err++; $display("FAIL wr_addr[%0d]: got %h want %h", i, sram_addr, AW'(32'h8 + i)); end
      n_cmp++; if (sram_wdata !== D_WORDS[i]) begin n_err++; $display("FAIL wr_wdata[%0d]: got %h want %h", i, sram_wdata, D_WORDS[i]); end
      @(negedge clk);
    end
    creq = '0;
    #1;
    n_cmp++; if (cresp.ready !== 1'b0) begin n_err++; $display("FAIL wr_after_ready: got %b want 0", cresp.ready); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem[10'(8 + i)] !== D_WORDS[i]) begin n_err++; $display("FAIL wr_mem[%0d]: got %h want %h", i, mem[10'(8 + i)], D_WORDS[i]); end
    end
  endtask

  task automatic test_subword_write();
    creq          = '0;
    creq.valid    = 1'b1;
    creq.is_write = 1'b1;
    creq.size     = MSIZE1;
    creq.addr     = 32'h44;
    creq.len      = MLEN1;
    creq.strobe   = 4'b0010;
    creq.data     = 32'hAABB_CCDD;
    @(negedge clk);
    #1;
    n_cmp++; if (cresp.ready !== 1'b1 || cresp.last !== 1'b1) begin n_err++; $display("FAIL sub_ready_last: got %b%b want 11", cresp.ready, cresp.last); end
    n_cmp++; if (sram_we !== 4'b0010) begin n_err++; $display("FAIL sub_we: got %b want 0010", sram_we); end
    n_cmp++; if (sram_addr !== 16'h0011) begin n_err++; $display("FAIL sub_addr: got %h want 0011", sram_addr); end
    @(negedge clk);
    creq = '0;
    #1;
    n_cmp++; if (cresp.ready !== 1'b0) begin n_err++; $display("FAIL sub_after_ready: got %b want 0", cresp.ready); end
    @(negedge clk);
    n_cmp++; if (mem[10'h011] !== 32'h1122_CC44) begin n_err++; $display("FAIL sub_mem: got %h want 1122cc44", mem[10'h011]); end
  endtask

  task automatic test_back_to_back();
    creq          = '0;
    creq.valid    = 1'b1;
    creq.is_write = 1'b1;
    creq.size     = MSIZE4;
    creq.addr     = 32'h80;
    creq.len      = MLEN4;
    creq.strobe   = 4'hF;
    creq.data     = E_WORDS[0];
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      creq.data = E_WORDS[i];
      #1;
      n_cmp++; if (cresp.ready !== 1'b1) begin n_err++; $display("FAIL b2b_wr_ready[%0d]: got %b want 1", i, cresp.ready); end
      @(negedge clk);
    end
    creq.is_write = 1'b0;
    creq.strobe   = 4'h0;
    creq.data     = '0;
    #1;
    n_cmp++; if (sram_en !== 1'b1 || sram_addr !== 16'h0020) begin n_err++; $display("FAIL b2b_rd_issue: got en=%b addr=%h want en=1 addr=0020", sram_en, sram_addr); end
    n_cmp++; if (cresp.ready !== 1'b0) begin n_err++; $display("FAIL b2b_idle_ready: got %b want 0", cresp.ready); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (cresp.ready !== 1'b1 || cresp.data !== E_WORDS[i]) begin n_err++; $display("FAIL b2b_rd[%0d]: got ready=%b data=%h want ready=1 data=%h", i, cresp.ready, cresp.data, E_WORDS[i]); end
      n_cmp++; if (cresp.last !== (i == 3)) begin n_err++; $display("FAIL b2b_rd_last[%0d]: got %b want %b", i, cresp.last, (i == 3)); end
      @(negedge clk);
    end
    creq = '0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    creq          = '0;
    creq.valid    = 1'b1;
    creq.is_write = 1'b1;
    creq.size     = MSIZE4;
    creq.addr     = 32'hC0;
    creq.len      = MLEN4;
    creq.strobe   = 4'hF;
    creq.data     = F_WORDS[0];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      creq.data = F_WORDS[i];
      #1;
      n_cmp++; if (cresp.ready !== 1'b1) begin n_err++; $display("FAIL abt_ready[%0d]: got %b want 1", i, cresp.ready); end
      @(negedge clk);
    end
    creq.valid = 1'b0;
    creq.data  = F_WORDS[2];
    #1;
    n_cmp++; if (cresp.ready !== 1'b0 || cresp.last !== 1'b0) begin n_err++; $display("FAIL abt_drop_resp: got %b%b want 00", cresp.ready, cresp.last); end
    n_cmp++; if (sram_en !== 1'b0 || sram_we !== 4'h0) begin n_err++; $display("FAIL abt_drop_sram: got en=%b we=%h want en=0 we=0", sram_en, sram_we); end
    @(negedge clk);
    // A fresh request must be taken straight from IDLE.
    creq          = '0;
    creq.valid    = 1'b1;
    creq.addr     = 32'hC0;
    creq.len      = MLEN1;
    #1;
    n_cmp++; if (sram_en !== 1'b1 || sram_addr !== 16'h0030) begin n_err++; $display("FAIL abt_idle_issue: got en=%b addr=%h want en=1 addr=0030", sram_en, sram_addr); end
    n_cmp++; if (cresp.ready !== 1'b0) begin n_err++; $display("FAIL abt_idle_ready: got %b want 0", cresp.ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (cresp.ready !== 1'b1 || cresp.last !== 1'b1 || cresp.data !== F_WORDS[0]) begin n_err++; $display("FAIL abt_rd: got %h want ready=1 last=1 data=%h", cresp, F_WORDS[0]); end
    @(negedge clk);
    creq = '0;
    @(negedge clk);
    n_cmp++; if (mem[10'h030] !== F_WORDS[0]) begin n_err++; $display("FAIL abt_mem0: got %h want %h", mem[10'h030], F_WORDS[0]); end
    n_cmp++; if (mem[10'h031] !== F_WORDS[1]) begin n_err++; $display("FAIL abt_mem1: got %h want %h", mem[10'h031], F_WORDS[1]); end
    n_cmp++; if (mem[10'h032] !== 32'h5555_0002) begin n_err++; $display("FAIL abt_mem2: got %h want 55550002", mem[10'h032]); end
    n_cmp++; if (mem[10'h033] !== 32'h5555_0003) begin n_err++; $display("FAIL abt_mem3: got %h want 55550003", mem[10'h033]); end
  endtask

  task automatic test_reset_mid_burst();
    creq       = '0;
    creq.valid = 1'b1;
    creq.size  = MSIZE4;
    creq.addr  = 32'h400;
    creq.len   = MLEN4;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (cresp.ready !== 1'b1 || cresp.data !== A_WORDS[i]) begin n_err++; $display("FAIL mrst_beat[%0d]: got ready=%b data=%h want ready=1 data=%h", i, cresp.ready, cresp.data, A_WORDS[i]); end
      if (i == 0) @(negedge clk);
    end
    #1;
    resetn = 1'b0;
    #1;
    n_cmp++; if (cresp !== '0) begin n_err++; $display("FAIL mrst_cresp: got %h want 0", cresp); end
    n_cmp++; if (sram_en !== 1'b0 || sram_addr !== 16'h0) begin n_err++; $display("FAIL mrst_sram: got en=%b addr=%h want en=0 addr=0", sram_en, sram_addr); end
    @(negedge clk);
    creq   = '0;
    resetn = 1'b1;
    @(negedge clk);
    creq       = '0;
    creq.valid = 1'b1;
    creq.addr  = 32'h40C;
    creq.len   = MLEN1;
    #1;
    n_cmp++; if (sram_en !== 1'b1 || sram_addr !== 16'h0103) begin n_err++; $display("FAIL mrst_new_issue: got en=%b addr=%h want en=1 addr=0103", sram_en, sram_addr); end
    n_cmp++; if (cresp.ready !== 1'b0) begin n_err++; $display("FAIL mrst_new_idle_ready: got %b want 0", cresp.ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (cresp.ready !== 1'b1 || cresp.last !== 1'b1 || cresp.data !== A_WORDS[3]) begin n_err++; $display("FAIL mrst_new_rd: got %h want ready=1 last=1 data=%h", cresp, A_WORDS[3]); end
    @(negedge clk);
    creq = '0;
    #1;
    n_cmp++; if (cresp.ready !== 1'b0) begin n_err++; $display("FAIL mrst_after_ready: got %b want 0", cresp.ready); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write_burst();
    test_subword_write();
    test_back_to_back();
    test_abort();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
